// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1) with a first-word-fall-through byte FIFO, clk_sys domain.
// Define UART_RX_PARITY_EN to build 8E1 framing with a parity_err flag.
module uart_rx_fifo #(
    parameter int CLK_RATE = 84_000_000,
    parameter int BAUD     = 115_200,
    parameter int FIFO_AW  = 4
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               rx,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               frame_err,
    output logic               overrun,
`ifdef UART_RX_PARITY_EN
    output logic               parity_err,
`endif
    input  logic               err_clr
);

    localparam int DIV = (CLK_RATE + BAUD / 2) / BAUD;
    localparam int MID = DIV / 2;
    localparam int TW  = $clog2(DIV);
    localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
    localparam logic [TW-1:0] T_VOTE = TW'(MID + 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // Stage p0/p1: two-flop synchroniser; vld_pN marks that rx_s now reflects the real line
    logic rx_meta, rx_s, rx_prev, vld_p0, vld_p1, armed;
    logic [1:0] samp;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            armed   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            // A line held low through reset must go high before a start edge counts
            if (vld_p1 && rx_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys)
        samp <= {samp[0], rx_s};

    // Vote completes on the cycle holding the third sample (timer = MID+1)
    logic vote, at_vote;
    assign vote    = (samp[1] & samp[0]) | (samp[1] & rx_s) | (samp[0] & rx_s);

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          brk, brk_n, push_req, push_n, ferr_set;
`ifdef UART_RX_PARITY_EN
    logic          par_bad, par_bad_n, perr_set;
`endif

    assign at_vote = (timer == T_VOTE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            brk      <= 1'b0;
            push_req <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            brk      <= brk_n;
            push_req <= push_n;
`ifdef UART_RX_PARITY_EN
            par_bad  <= par_bad_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        brk_n     = brk;
        push_n    = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        perr_set  = 1'b0;
`endif
        if (state != IDLE)
            timer_n = (timer == T_LAST) ? '0 : timer + TW'(1);
        case (state)
            IDLE: begin
                if (armed && rx_prev && !rx_s) begin
                    state_n = START;
                    timer_n = '0;
                end
            end
            START: begin
                if (at_vote) begin
                    state_n   = vote ? IDLE : DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (at_vote) begin
                    shreg_n   = {vote, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_vote) begin
                    par_bad_n = vote ^ (^shreg);
                    perr_set  = vote ^ (^shreg);
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (brk) begin
                    if (rx_s) begin
                        state_n = IDLE;
                        brk_n   = 1'b0;
                    end
                end else if (at_vote) begin
                    if (vote) begin
                        // Leave half a bit early so a back-to-back start edge is not missed
                        state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                        push_n  = !par_bad;
`else
                        push_n  = 1'b1;
`endif
                    end else begin
                        ferr_set = 1'b1;
                        brk_n    = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (state_n == IDLE)
            timer_n = '0;
    end

    // FIFO: pointers carry an extra wrap bit; rx_data is a registered head
    logic [7:0]       mem [0:2**FIFO_AW-1];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic             empty, full, pop, wr_ok;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = ((wr_ptr ^ rd_ptr) == {1'b1, {FIFO_AW{1'b0}}});
    assign rx_valid   = !empty;
    assign pop        = rx_valid & rx_ready;
    assign wr_ok      = push_req & (!full | pop);
    assign rd_ptr_n   = rd_ptr + (FIFO_AW + 1)'(pop);
    assign fifo_level = wr_ptr - rd_ptr;

    always_ff @(posedge clk_sys)
        if (wr_ok)
            mem[wr_ptr[FIFO_AW-1:0]] <= shreg;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rx_data <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + (FIFO_AW + 1)'(1);
            rd_ptr <= rd_ptr_n;
            // Bypass the incoming byte when it becomes the new head
            if (wr_ok && (wr_ptr == rd_ptr_n))
                rx_data <= shreg;
            else if (pop && (rd_ptr_n != wr_ptr))
                rx_data <= mem[rd_ptr_n[FIFO_AW-1:0]];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (ferr_set)
                frame_err <= 1'b1;
            else if (err_clr)
                frame_err <= 1'b0;
            if (push_req && full && !pop)
                overrun <= 1'b1;
            else if (err_clr)
                overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (perr_set)
                parity_err <= 1'b1;
            else if (err_clr)
                parity_err <= 1'b0;
`endif
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Serial receiver for the core's UART_RX pin. It supports MIDI-in, serial console and tape-loader paths. It deserialises 8N1 frames into bytes and buffers them in a small FIFO. The buffer is drained by the tsconf port logic over a valid/ready handshake. It is the receive counterpart of the UART_TX merge logic and runs in the clk_sys domain.

Parameters:
CLK_RATE, 84_000_000, clk_sys frequency in Hz.
BAUD, 115_200, line rate in bit/s; DIV = (CLK_RATE + BAUD/2) / BAUD, DIV must be >= 8.
FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW entries.

Ports:
clk_sys  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
rx  in  1  asynchronous serial input; idle high.
rx_data  out  8  byte at the FIFO head.
rx_valid  out  1  FIFO non-empty; rx_data valid.
rx_ready  in  1  consumer accepts the head byte when rx_valid & rx_ready at a clk_sys edge.
fifo_level  out  FIFO_AW+1  number of bytes held, 0..2^FIFO_AW.
frame_err  out  1  sticky: a stop bit was sampled low.
overrun  out  1  sticky: a byte was received while the FIFO was full.
err_clr  in  1  clears frame_err and overrun (plus parity_err when that feature is built).

Behaviour:
- Clocking and reset: one clock, clk_sys. Reset is synchronous and active-high.
- rx synchroniser: two flops, both reset to 1. All logic uses the synchronised rx_s.
- Bit timer: counter over 0..DIV-1. Sample point is at DIV/2 (integer division).
- Majority vote: the bit value is the majority of rx_s at cycles DIV/2-1, DIV/2 and DIV/2+1 of the bit.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge on rx_s (prev 1, now 0) clears the timer and moves to START.
  - START: at the sample point, vote 0 moves to DATA with bit_idx=0; vote 1 is a glitch and returns to IDLE with no error.
  - DATA: one voted sample per bit period, shifted in LSB first. After bit_idx=7, move to STOP.
  - STOP: at the sample point:
    - Vote 1: push the byte and go to IDLE immediately, i.e. half a bit early, so back-to-back frames are tolerated.
    - Vote 0: set frame_err, discard the byte, then wait in STOP until rx_s=1 before returning to IDLE (break condition).
- Latency: the FIFO write occurs on the cycle after the stop-bit sample point. rx_valid rises on the following cycle.
- FIFO: 2^FIFO_AW x 8, pointers FIFO_AW+1 bits wide, free-running wrap.
  - Empty: pointers equal.
  - Full: pointers differ only in the MSB.
  - rx_data is the registered head (first-word-fall-through).
- Pop: rx_valid & rx_ready. rx_ready while empty is ignored. rx_data and rx_valid are stable while rx_valid=1 and rx_ready=0.
- Push when full: the byte is dropped, overrun is set, FIFO contents are unchanged.
- Simultaneous push and pop:
  - When full: the pop frees space and the push succeeds; overrun is not set and fifo_level stays 2^FIFO_AW.
  - Otherwise: fifo_level is unchanged.
- Errors:
  - A set event and err_clr in the same cycle: the set wins.
  - err_clr does not affect the FIFO or the FSM.
- Reset values:
  - rx_data = 0, rx_valid = 0, fifo_level = 0.
  - frame_err = 0, overrun = 0.
  - FSM in IDLE, timer = 0, shift register = 0.
- Reset mid-frame: the partial byte is discarded and the FIFO is emptied. After reset the receiver waits for a fresh falling edge; a line already low is ignored until it returns high.

Optional Feature:
UART_RX_PARITY_EN:
- When defined, frames are 8E1: an even-parity bit follows data bit 7 and is sampled in an extra PARITY state between DATA and STOP.
- Adds output parity_err (1 bit, sticky, reset 0, cleared by err_clr).
- On a mismatch the byte is discarded and parity_err is set. The stop bit is still checked, and frame_err is set as well if the stop bit is low.
- When not defined: there is no PARITY state, no parity_err port, and frames are 8N1 as above.

Test Plan:
Bench parameters: CLK_RATE=1_600_000, BAUD=100_000 (DIV=16), FIFO_AW=2.
1. Send 0xA5 8N1 with rx_ready=0 -> rx_valid=1, rx_data=0xA5, fifo_level=1. The write happens 1 cycle after the stop sample and rx_valid rises 2 cycles after it. No error flags.
2. Send 0x01,0x02,0x03,0x04,0x05 back-to-back with rx_ready=0 -> fifo_level=4 and overrun=1. Then hold rx_ready=1 -> reads 0x01..0x04, then rx_valid=0. Pulse err_clr -> overrun=0.
3. Send 0x3C with the stop bit driven low for 1.5 bit periods -> frame_err=1, fifo_level=0. Then send 0x55 -> received correctly as 0x55.
4. Drive a 5-cycle low glitch on rx -> no byte and no error, FSM back in IDLE. A 1-cycle high spike at the centre of data bit 3 of 0x00 -> majority vote still yields 0x00.
5. With the FIFO full, complete a frame on the same cycle as a pop -> overrun=0, fifo_level=4, and the new byte appears at the tail.
6. Assert reset for 1 cycle during data bit 4 of an in-flight frame -> all outputs return to 0. Next frame 0x7E is received correctly. With UART_RX_PARITY_EN, 0x7E sent with parity 1 -> parity_err=1, no byte.
